// File: rtl/ocl_axil_arbiter_pkg.sv
// ocl_arb_pkg
// Shared types and constants for the OCL / management-path AXI4-Lite arbiter.
//   arb_state_t    : transaction FSM states
//   RESP_*         : AXI-L response codes used by the arbiter
//   TIMEOUT_RDATA  : read data returned on a watchdog completion
//   NUM_MST        : number of upstream host paths
package ocl_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } arb_state_t;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam int          NUM_MST       = 2;

endpackage

// File: rtl/ocl_axil_arbiter.sv
// ocl_axil_arbiter
// Shares one AXI4-Lite slave (the register core) between two host paths:
// master 0 = PCIe OCL (BAR0), master 1 = SDA/BAR1 management. Whole
// transactions are serialised, one at a time, with round-robin tie breaking.
// A response watchdog completes a hung B/R locally with SLVERR.
//
// Ports (master i: 1-bit signals at bit [i], buses at [W*i +: W]):
//   clk_main_a0, rst_main_n    clock, async active-low reset
//   s_aw*/s_w*/s_b*/s_ar*/s_r* per-master AXI-L slave ports (from reg slices)
//   m_aw*/m_w*/m_b*/m_ar*/m_r* single AXI-L master port (to the core)
//   grant_o                    one-hot owner of the current transaction
//   timeout_cnt                saturating count of watchdog completions
module ocl_axil_arbiter
    import ocl_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                          clk_main_a0,
    input  logic                          rst_main_n,
    // upstream masters
    input  logic [NUM_MST-1:0]            s_awvalid,
    input  logic [NUM_MST*ADDR_W-1:0]     s_awaddr,
    output logic [NUM_MST-1:0]            s_awready,
    input  logic [NUM_MST-1:0]            s_wvalid,
    input  logic [NUM_MST*DATA_W-1:0]     s_wdata,
    input  logic [NUM_MST*DATA_W/8-1:0]   s_wstrb,
    output logic [NUM_MST-1:0]            s_wready,
    output logic [NUM_MST-1:0]            s_bvalid,
    output logic [NUM_MST*2-1:0]          s_bresp,
    input  logic [NUM_MST-1:0]            s_bready,
    input  logic [NUM_MST-1:0]            s_arvalid,
    input  logic [NUM_MST*ADDR_W-1:0]     s_araddr,
    output logic [NUM_MST-1:0]            s_arready,
    output logic [NUM_MST-1:0]            s_rvalid,
    output logic [NUM_MST*DATA_W-1:0]     s_rdata,
    output logic [NUM_MST*2-1:0]          s_rresp,
    input  logic [NUM_MST-1:0]            s_rready,
    // downstream slave (register core)
    output logic                          m_awvalid,
    output logic [ADDR_W-1:0]             m_awaddr,
    input  logic                          m_awready,
    output logic                          m_wvalid,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W/8-1:0]           m_wstrb,
    input  logic                          m_wready,
    input  logic                          m_bvalid,
    input  logic [1:0]                    m_bresp,
    output logic                          m_bready,
    output logic                          m_arvalid,
    output logic [ADDR_W-1:0]             m_araddr,
    input  logic                          m_arready,
    input  logic                          m_rvalid,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic [1:0]                    m_rresp,
    output logic                          m_rready,
    // status
    output logic [NUM_MST-1:0]            grant_o,
    output logic [15:0]                   timeout_cnt
);

    localparam int         STRB_W  = DATA_W / 8;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    arb_state_t         state_q;
    logic               owner_q;
    logic               last_grant_q;
    logic               aw_done_q;
    logic               w_done_q;
    logic               local_q;       // watchdog completion already presented
    logic [15:0]        wd_q;
    logic [NUM_MST-1:0] grant_q;
    logic [15:0]        tmo_cnt_q;

    // Per-master views of the flattened payload buses
    logic [ADDR_W-1:0]  aw_addr_a [NUM_MST];
    logic [DATA_W-1:0]  w_data_a  [NUM_MST];
    logic [STRB_W-1:0]  w_strb_a  [NUM_MST];
    logic [ADDR_W-1:0]  ar_addr_a [NUM_MST];

    for (genvar g = 0; g < NUM_MST; g++) begin : g_unpack
        assign aw_addr_a[g] = s_awaddr[g*ADDR_W +: ADDR_W];
        assign w_data_a[g]  = s_wdata[g*DATA_W +: DATA_W];
        assign w_strb_a[g]  = s_wstrb[g*STRB_W +: STRB_W];
        assign ar_addr_a[g] = s_araddr[g*ADDR_W +: ADDR_W];
    end

    // Round-robin: on a tie the master that did not win last time goes.
    logic [NUM_MST-1:0] req;
    logic               win;
    assign req = s_awvalid | s_arvalid;
    assign win = (&req) ? ~last_grant_q : ~req[0];

    // Owner-side response path and watchdog selection
    logic              slv_valid;
    logic              local_sel;
    logic              rsp_ready;
    logic              awready_c, wready_c, arready_c;
    logic              bvalid_c, rvalid_c;
    logic [1:0]        rsp_code;
    logic [DATA_W-1:0] rdata_c;
    logic              aw_hs, w_hs, ar_hs, rsp_hs;

    // A slave response arriving in the very cycle the watchdog expires
    // still wins; once the local completion is shown it is held until taken.
    always_comb begin
        slv_valid = (state_q == RDATA) ? m_rvalid : m_bvalid;
        local_sel = local_q | ((wd_q == WD_LAST) & ~slv_valid);
        rsp_ready = (state_q == RDATA) ? s_rready[owner_q] : s_bready[owner_q];
    end

    always_comb begin
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_arvalid = 1'b0;
        m_bready  = 1'b0;
        m_rready  = 1'b0;
        awready_c = 1'b0;
        wready_c  = 1'b0;
        arready_c = 1'b0;
        bvalid_c  = 1'b0;
        rvalid_c  = 1'b0;
        rsp_code  = RESP_OKAY;
        rdata_c   = '0;
        case (state_q)
            IDLE: begin
                // Drain stray late responses so they never reach a master
                m_bready = 1'b1;
                m_rready = 1'b1;
            end
            WADDR: begin
                m_awvalid = s_awvalid[owner_q] & ~aw_done_q;
                m_wvalid  = s_wvalid[owner_q] & ~w_done_q;
                awready_c = m_awready & ~aw_done_q;
                wready_c  = m_wready & ~w_done_q;
            end
            WRESP: begin
                if (local_sel) begin
                    bvalid_c = 1'b1;
                    rsp_code = RESP_SLVERR;
                end else begin
                    bvalid_c = m_bvalid;
                    rsp_code = m_bresp;
                    m_bready = s_bready[owner_q];
                end
            end
            RADDR: begin
                m_arvalid = s_arvalid[owner_q];
                arready_c = m_arready;
            end
            RDATA: begin
                if (local_sel) begin
                    rvalid_c = 1'b1;
                    rsp_code = RESP_SLVERR;
                    rdata_c  = DATA_W'(TIMEOUT_RDATA);
                end else begin
                    rvalid_c = m_rvalid;
                    rsp_code = m_rresp;
                    rdata_c  = m_rdata;
                    m_rready = s_rready[owner_q];
                end
            end
            default: ;
        endcase
    end

    assign aw_hs  = m_awvalid & m_awready;
    assign w_hs   = m_wvalid & m_wready;
    assign ar_hs  = m_arvalid & m_arready;
    assign rsp_hs = (bvalid_c | rvalid_c) & rsp_ready;

    assign m_awaddr = aw_addr_a[owner_q];
    assign m_wdata  = w_data_a[owner_q];
    assign m_wstrb  = w_strb_a[owner_q];
    assign m_araddr = ar_addr_a[owner_q];

    // grant_q is zero in IDLE, so it doubles as the fan-out mask
    for (genvar g = 0; g < NUM_MST; g++) begin : g_fanout
        assign s_awready[g]                = grant_q[g] & awready_c;
        assign s_wready[g]                 = grant_q[g] & wready_c;
        assign s_arready[g]                = grant_q[g] & arready_c;
        assign s_bvalid[g]                 = grant_q[g] & bvalid_c;
        assign s_rvalid[g]                 = grant_q[g] & rvalid_c;
        assign s_bresp[g*2 +: 2]           = grant_q[g] ? rsp_code : RESP_OKAY;
        assign s_rresp[g*2 +: 2]           = grant_q[g] ? rsp_code : RESP_OKAY;
        assign s_rdata[g*DATA_W +: DATA_W] = grant_q[g] ? rdata_c : '0;
    end

    assign grant_o     = grant_q;
    assign timeout_cnt = tmo_cnt_q;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            local_q      <= 1'b0;
            wd_q         <= '0;
            grant_q      <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        // Write takes priority when the winner offers both
                        state_q      <= s_awvalid[win] ? WADDR : RADDR;
                        owner_q      <= win;
                        last_grant_q <= win;
                        grant_q      <= win ? 2'b10 : 2'b01;
                        aw_done_q    <= 1'b0;
                        w_done_q     <= 1'b0;
                    end
                end
                WADDR: begin
                    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                        state_q <= WRESP;
                        wd_q    <= '0;
                        local_q <= 1'b0;
                    end else begin
                        aw_done_q <= aw_done_q | aw_hs;
                        w_done_q  <= w_done_q | w_hs;
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        state_q <= RDATA;
                        wd_q    <= '0;
                        local_q <= 1'b0;
                    end
                end
                WRESP, RDATA: begin
                    if (rsp_hs) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        if (local_sel && tmo_cnt_q != 16'hFFFF)
                            tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end else begin
                        if (wd_q != WD_LAST)
                            wd_q <= wd_q + 16'd1;
                        if (local_sel)
                            local_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ocl_axil_arbiter.sv
module tb_ocl_axil_arbiter;
    import ocl_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk_main_a0 = 1'b0;
    logic rst_main_n  = 1'b0;
    always #5 clk_main_a0 = ~clk_main_a0;

    logic [1:0]      s_awvalid, s_awready, s_wvalid, s_wready;
    logic [2*AW-1:0] s_awaddr, s_araddr;
    logic [2*DW-1:0] s_wdata, s_rdata;
    logic [7:0]      s_wstrb;
    logic [1:0]      s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [3:0]      s_bresp, s_rresp;
    logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic            m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0]   m_awaddr, m_araddr;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [3:0]      m_wstrb;
    logic [1:0]      m_bresp, m_rresp;
    logic [1:0]      grant_o;
    logic [15:0]     timeout_cnt;

    int checks   = 0;
    int failures = 0;

    ocl_axil_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .grant_o(grant_o), .timeout_cnt(timeout_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive 2 time units after the rising edge, sample at the falling edge
    task automatic next();
        @(posedge clk_main_a0);
        #2;
    endtask

    task automatic mid();
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        s_awvalid = '0; s_awaddr = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0;
        s_bready = '0; s_arvalid = '0; s_araddr = '0; s_rready = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
        m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;

        // ---- reset state
        #12;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_tmo", timeout_cnt, 16'h0);
        chk("rst_mvalid", {m_awvalid, m_wvalid, m_arvalid}, 3'b000);
        chk("rst_mready", {m_bready, m_rready}, 2'b11);
        chk("rst_sready", {s_awready, s_wready, s_arready}, 6'b0);
        chk("rst_svalid", {s_bvalid, s_rvalid}, 4'b0);
        rst_main_n = 1'b1;

        // ---- tie on reads, 4 rounds: grants alternate starting with master 0
        next();
        s_arvalid = 2'b11; s_araddr = {32'h0000_0200, 32'h0000_0100}; s_rready = 2'b11;
        mid();
        chk("arb_cycle_no_arvalid", m_arvalid, 1'b0);
        for (int r = 0; r < 4; r++) begin
            int o;
            o = (exp_g[r] == 2'b10) ? 1 : 0;
            next(); mid();
            chk("rr_grant", grant_o, exp_g[r]);
            chk("rr_m_arvalid", m_arvalid, 1'b1);
            chk("rr_m_araddr", m_araddr, (o == 1) ? 32'h0000_0200 : 32'h0000_0100);
            chk("rr_s_arready", s_arready, exp_g[r]);
            next();
            m_rvalid = 1'b1; m_rdata = 32'h1000 + r; m_rresp = 2'b00;
            mid();
            chk("rr_s_rvalid", s_rvalid, exp_g[r]);
            chk("rr_s_rdata", s_rdata[o*32 +: 32], 32'h1000 + r);
            next();
            m_rvalid = 1'b0;
            mid();
            chk("rr_idle_grant", grant_o, 2'b00);
            chk("rr_idle_rvalid", s_rvalid, 2'b00);
        end
        s_arvalid = 2'b00;

        // ---- master 0 single write, slave always ready
        next();
        s_awvalid = 2'b01; s_awaddr = {32'h0, 32'h0000_0500};
        s_wvalid = 2'b01; s_wdata = {32'h0, 32'hA5A5_A5A5}; s_wstrb = 8'h0F;
        s_bready = 2'b01;
        mid();
        chk("wr_arb_no_awvalid", m_awvalid, 1'b0);
        next(); mid();
        chk("wr_grant", grant_o, 2'b01);
        chk("wr_m_awvalid", m_awvalid, 1'b1);
        chk("wr_m_awaddr", m_awaddr, 32'h0000_0500);
        chk("wr_m_wvalid", m_wvalid, 1'b1);
        chk("wr_m_wdata", m_wdata, 32'hA5A5_A5A5);
        chk("wr_m_wstrb", m_wstrb, 4'hF);
        chk("wr_s_readys", {s_awready, s_wready}, 4'b0101);
        next();
        s_awvalid = 2'b00; s_wvalid = 2'b00; m_bvalid = 1'b1; m_bresp = 2'b00;
        mid();
        chk("wr_s_bvalid", s_bvalid, 2'b01);
        chk("wr_s_bresp", s_bresp, 4'b0000);
        chk("wr_no_dup_aw", m_awvalid, 1'b0);
        next();
        m_bvalid = 1'b0;
        mid();
        chk("wr_idle_grant", grant_o, 2'b00);
        chk("wr_idle_bvalid", s_bvalid, 2'b00);

        // ---- master 0 offers write and read together: write first
        next();
        s_awvalid = 2'b01; s_awaddr = {32'h0, 32'h0000_0504};
        s_wvalid = 2'b01; s_wdata = {32'h0, 32'h1234_5678};
        s_arvalid = 2'b01; s_araddr = {32'h0, 32'h0000_0600}; s_rready = 2'b01;
        next(); mid();
        chk("wf_m_awvalid", m_awvalid, 1'b1);
        chk("wf_m_arvalid", m_arvalid, 1'b0);
        chk("wf_grant", grant_o, 2'b01);
        next();
        s_awvalid = 2'b00; s_wvalid = 2'b00; m_bvalid = 1'b1;
        mid();
        chk("wf_s_bvalid", s_bvalid, 2'b01);
        next();
        m_bvalid = 1'b0;
        mid();
        chk("wf_gap_arvalid", m_arvalid, 1'b0);
        chk("wf_gap_grant", grant_o, 2'b00);
        next(); mid();
        chk("wf_rd_arvalid", m_arvalid, 1'b1);
        chk("wf_rd_araddr", m_araddr, 32'h0000_0600);
        chk("wf_rd_grant", grant_o, 2'b01);
        next();
        s_arvalid = 2'b00; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D;
        mid();
        chk("wf_rd_rvalid", s_rvalid, 2'b01);
        chk("wf_rd_rdata", s_rdata[31:0], 32'h0BAD_F00D);
        next();
        m_rvalid = 1'b0;
        mid();
        chk("wf_end_grant", grant_o, 2'b00);

        // ---- master 1 write, W accepted 3 cycles after AW
        next();
        s_awvalid = 2'b10; s_awaddr = {32'h0000_0700, 32'h0};
        s_wvalid = 2'b10; s_wdata = {32'hCAFE_0001, 32'h0}; s_wstrb = 8'h30;
        m_wready = 1'b0; s_bready = 2'b10;
        next(); mid();
        chk("aw_grant", grant_o, 2'b10);
        chk("aw_m_awvalid", m_awvalid, 1'b1);
        chk("aw_m_awaddr", m_awaddr, 32'h0000_0700);
        chk("aw_s_wready", s_wready, 2'b00);
        for (int k = 0; k < 2; k++) begin
            next(); mid();
            chk("aw_nodup", m_awvalid, 1'b0);
            chk("aw_s_awready", s_awready, 2'b00);
            chk("aw_not_wresp", m_bready, 1'b0);
        end
        next();
        m_wready = 1'b1;
        mid();
        chk("aw_w_late_awvalid", m_awvalid, 1'b0);
        chk("aw_w_late_wready", s_wready, 2'b10);
        chk("aw_w_late_wdata", m_wdata, 32'hCAFE_0001);
        chk("aw_w_late_wstrb", m_wstrb, 4'h3);
        next();
        s_awvalid = 2'b00; s_wvalid = 2'b00;
        mid();
        chk("aw_in_wresp", m_bready, 1'b1);
        next();
        m_bvalid = 1'b1; m_bresp = 2'b00;
        mid();
        chk("aw_s_bvalid", s_bvalid, 2'b10);
        next();
        m_bvalid = 1'b0;
        mid();
        chk("aw_end_grant", grant_o, 2'b00);

        // ---- watchdog: slave never answers B
        next();
        s_awvalid = 2'b01; s_awaddr = {32'h0, 32'h0000_0800};
        s_wvalid = 2'b01; s_wdata = {32'h0, 32'h0000_0055}; s_wstrb = 8'h0F;
        s_bready = 2'b00;
        next();
        next();
        s_awvalid = 2'b00; s_wvalid = 2'b00;
        for (int c = 1; c < 15; c++) next();
        mid();
        chk("wd_cycle15_bvalid", s_bvalid, 2'b00);
        next(); mid();
        chk("wd_cycle16_bvalid", s_bvalid, 2'b01);
        chk("wd_cycle16_bresp", s_bresp[1:0], RESP_SLVERR);
        chk("wd_cycle16_mbready", m_bready, 1'b0);
        next();
        s_bready = 2'b01;
        mid();
        chk("wd_hold_bvalid", s_bvalid, 2'b01);
        next();
        s_bready = 2'b00;
        mid();
        chk("wd_idle_grant", grant_o, 2'b00);
        chk("wd_tmo_cnt", timeout_cnt, 16'd1);
        next();
        m_bvalid = 1'b1; m_bresp = 2'b00;
        mid();
        chk("late_b_mbready", m_bready, 1'b1);
        chk("late_b_hidden", s_bvalid, 2'b00);
        next();
        m_bvalid = 1'b0;
        mid();
        chk("late_b_after", {s_bvalid, grant_o}, 4'b0000);

        // ---- reset pulse during RDATA
        next();
        s_arvalid = 2'b01; s_araddr = {32'h0, 32'h0000_0900}; s_rready = 2'b00;
        next();
        next();
        s_arvalid = 2'b00;
        mid();
        chk("rst_rd_grant_pre", grant_o, 2'b01);
        chk("rst_rd_mrready_pre", m_rready, 1'b0);
        #1;
        rst_main_n = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h7777_7777;
        #1;
        chk("rst_rd_grant", grant_o, 2'b00);
        chk("rst_rd_mrready", m_rready, 1'b1);
        chk("rst_rd_rvalid", s_rvalid, 2'b00);
        chk("rst_rd_tmo", timeout_cnt, 16'd0);
        #1;
        rst_main_n = 1'b1;
        next();
        m_rvalid = 1'b0;
        mid();
        chk("rst_rd_idle", {s_rvalid, grant_o}, 4'b0000);
        next();
        s_awvalid = 2'b01; s_awaddr = {32'h0, 32'h0000_0A00};
        s_wvalid = 2'b01; s_wdata = {32'h0, 32'h0000_00AA}; s_bready = 2'b01;
        next(); mid();
        chk("post_rst_grant", grant_o, 2'b01);
        chk("post_rst_awaddr", m_awaddr, 32'h0000_0A00);
        next();
        s_awvalid = 2'b00; s_wvalid = 2'b00; m_bvalid = 1'b1;
        mid();
        chk("post_rst_bvalid", s_bvalid, 2'b01);
        next();
        m_bvalid = 1'b0;
        mid();
        chk("post_rst_idle", grant_o, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ocl_axil_arbiter.md
# ocl_axil_arbiter

Two-master to one-slave AXI4-Lite arbiter that shares the hello-world register core between the PCIe OCL path (BAR0, after the AXI-L register slice) and a second host path (SDA/BAR1 management). It serialises whole transactions with round-robin fairness. A response watchdog keeps a hung core from wedging either host path. Placement: between the register-slice outputs and the core's s_axi port.

## Interface
Parameters:
- ADDR_W, 32, AXI-L address width
- DATA_W, 32, AXI-L data width
- TIMEOUT, 256, cycles to wait for B/R from slave before local error completion

Ports (master index i: 1-bit signals at bit [i], buses at [W*i+W-1:W*i]):
- clk_main_a0  in  1  clock
- rst_main_n  in  1  reset, asynchronous, active-low
- s_awvalid/s_awaddr in, s_awready out  2 / 2*ADDR_W / 2  AW per master
- s_wvalid/s_wdata/s_wstrb in, s_wready out  2 / 2*DATA_W / 8 / 2  W per master
- s_bvalid/s_bresp out, s_bready in  2 / 4 / 2  B per master
- s_arvalid/s_araddr in, s_arready out  2 / 2*ADDR_W / 2  AR per master
- s_rvalid/s_rdata/s_rresp out, s_rready in  2 / 2*DATA_W / 4 / 2  R per master
- m_aw*, m_w*, m_b*, m_ar*, m_r*  mirrored  ADDR_W/DATA_W  single AXI-L master to core
- grant_o  out  2  one-hot owner of current transaction, 0 in IDLE
- timeout_cnt  out  16  saturating count of watchdog completions

## Operation
- States: IDLE, WADDR, WRESP, RADDR, RDATA. One transaction at a time, system-wide.
- Request of master i: awvalid[i] | arvalid[i].
- IDLE arbitration, registered:
  - Single requester wins.
  - Both requesting: the master not equal to last_grant wins. last_grant resets to 1, so master 0 wins the first tie.
  - Winner with both awvalid and arvalid: write first.
  - Transitions: IDLE→WADDR if write chosen, IDLE→RADDR if read chosen; last_grant ← winner.
- WADDR:
  - Owner's AW and W are forwarded independently to the slave. Each handshake is latched in aw_done/w_done.
  - Once aw_done, m_awvalid is forced 0; once w_done, m_wvalid is forced 0.
  - Both done (same cycle allowed) → WRESP.
- WRESP: m_b forwarded to the owner. Handshake → IDLE.
- RADDR: owner's AR forwarded. Handshake → RDATA.
- RDATA: m_r forwarded to the owner. Handshake → IDLE.
- Non-owners: all readys 0, bvalid/rvalid 0. Their requests stay pending.
- Watchdog:
  - A counter is cleared on entry to WRESP/RDATA and increments each cycle there.
  - At TIMEOUT-1 without slave valid, the arbiter drives s_bvalid (resp 2'b10) or s_rvalid (resp 2'b10, rdata 32'hDEAD_BEEF) to the owner. Slave bready/rready is 0 during this completion.
  - On owner handshake → IDLE; timeout_cnt increments, saturating at 16'hFFFF.
  - If slave valid and the watchdog fire in the same cycle, the slave response wins.
- IDLE: m_bready=m_rready=1. Stray late responses are accepted and dropped; no master sees them.
- AW/W/AR payloads pass through combinationally. No data buffering.

## Timing
- Reset state:
  - State IDLE, last_grant=1, grant_o=0, timeout_cnt=0.
  - All s_* readys/valids 0; m_awvalid/m_wvalid/m_arvalid 0; m_bready=m_rready=1.
- Arbitration adds exactly 1 cycle: request seen at edge T, m_awvalid/m_arvalid asserted from T+1.
- Back-to-back transactions have ≥1 IDLE cycle between the response handshake and the next address valid.
- Best-case write (slave readys high, bvalid next cycle): request to s_bvalid is 3 cycles. Read is the same.
- Reset mid-transaction: immediate return to IDLE. In-flight slave responses are dropped via the IDLE readys.

## Structure
- Package ocl_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, WADDR, WRESP, RADDR, RDATA}
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, TIMEOUT_RDATA=32'hDEAD_BEEF
  - NUM_MST=2
- No sub-module. Single file holding the FSM, the watchdog counter and the mux.

## Test plan
- Master 0 writes 0x0000_0500 ← 0xA5A5_A5A5 with slave always ready → slave sees the same addr/data/strb at T+1; master 0 gets bresp 0 at T+3; master 1 readys stay 0 throughout.
- Both masters assert arvalid on the same cycle, 4 rounds → grants alternate 0,1,0,1 (grant_o 01,10,01,10); each R reaches only its owner.
- Master 0 asserts awvalid and arvalid together → write completes first, then the read after one IDLE cycle.
- AW handshake 3 cycles before W handshake → no duplicate m_awvalid; WRESP entered only after W completes.
- Slave never returns B, TIMEOUT=16 → s_bresp=2'b10 at cycle 16 of WRESP; timeout_cnt=1. A late m_bvalid in IDLE is consumed and invisible to both masters.
- rst_main_n pulsed low during RDATA → outputs at reset values within the same cycle. A following transaction from master 0 completes normally.
